// File: rtl/countdown_ctrl.sv
// Front-panel controller for the BCD countdown datapath: holds the preset,
// edits it digit by digit from debounced buttons, and sequences the datapath
// through EDIT, RUN and DONE.
module countdown_ctrl #(
  parameter int unsigned ALARM_CYCLES = 500000000,
  parameter int unsigned BLINK_DIV    = 12500000,
  parameter logic [31:0] PRESET_RST   = 32'h00F00F10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_center,
  input  logic        finish,
  output logic [31:0] tmp1,
  output logic        go,
  output logic [2:0]  sel_digit,
  output logic        blink,
  output logic        alarm,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    ST_EDIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_BAD  = 2'd3
  } state_e;

  localparam int AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  // Bits holding real digits; the two filler nibbles are excluded.
  localparam logic [31:0] DIGIT_MASK = 32'hFF0FF0FF;

  // Largest legal value of the digit at a given selection index.
  function automatic logic [3:0] digit_max(input logic [2:0] sel);
    return (sel == 3'd1 || sel == 3'd3) ? 4'd5 : 4'd9;
  endfunction

  // Bit position of the digit at a given selection index inside tmp1.
  function automatic logic [4:0] digit_lsb(input logic [2:0] sel);
    case (sel)
      3'd0:    return 5'd0;
      3'd1:    return 5'd4;
      3'd2:    return 5'd12;
      3'd3:    return 5'd16;
      3'd4:    return 5'd24;
      default: return 5'd28;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [31:0]     tmp1_q, tmp1_d;
  logic [2:0]      sel_q, sel_d;
  logic            blink_q, blink_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic [AW-1:0]   alarm_cnt_q, alarm_cnt_d;
  logic            go_q, go_d;
  logic            alarm_q, alarm_d;
  logic [1:0]      sync_q, sync_d;

  logic            fin_edge;
  logic            sel_chg;
  logic [4:0]      cur_lsb;
  logic [3:0]      cur_digit;
  logic [3:0]      cur_max;
  logic [3:0]      new_digit;

  // Next state, preset editing and digit selection.
  always_comb begin
    state_d   = state_q;
    tmp1_d    = tmp1_q;
    sel_d     = sel_q;
    sel_chg   = 1'b0;
    sync_d    = {sync_q[0], finish};
    fin_edge  = sync_q[0] & ~sync_q[1];
    cur_lsb   = digit_lsb(sel_q);
    cur_digit = 4'(tmp1_q >> cur_lsb);
    cur_max   = digit_max(sel_q);
    new_digit = cur_digit;

    case (state_q)
      ST_EDIT: begin
        // One action per cycle: center > up > down > left > right.
        if (btn_center) begin
          if ((tmp1_q & DIGIT_MASK) != 32'd0) state_d = ST_RUN;
        end else if (btn_up) begin
          new_digit = (cur_digit >= cur_max) ? 4'd0 : cur_digit + 4'd1;
          tmp1_d    = (tmp1_q & ~(32'hF << cur_lsb)) | ({28'd0, new_digit} << cur_lsb);
        end else if (btn_down) begin
          new_digit = (cur_digit == 4'd0 || cur_digit > cur_max) ? cur_max : cur_digit - 4'd1;
          tmp1_d    = (tmp1_q & ~(32'hF << cur_lsb)) | ({28'd0, new_digit} << cur_lsb);
        end else if (btn_left) begin
          sel_d   = (sel_q >= 3'd5) ? 3'd0 : sel_q + 3'd1;
          sel_chg = 1'b1;
        end else if (btn_right) begin
          sel_d   = (sel_q == 3'd0 || sel_q > 3'd5) ? 3'd5 : sel_q - 3'd1;
          sel_chg = 1'b1;
        end
      end
      ST_RUN: begin
        // A finish edge beats a simultaneous abort.
        if (fin_edge)        state_d = ST_DONE;
        else if (btn_center) state_d = ST_EDIT;
      end
      ST_DONE: begin
        if (btn_center || alarm_cnt_q == ALARM_LAST) state_d = ST_EDIT;
      end
      default: state_d = ST_EDIT;
    endcase
  end

  // Registered outputs, alarm timer and edit blink timer.
  always_comb begin
    go_d        = (state_d == ST_RUN) || (state_d == ST_DONE);
    alarm_d     = (state_d == ST_DONE);
    alarm_cnt_d = '0;
    blink_d     = 1'b0;
    blink_cnt_d = '0;

    if (state_q == ST_DONE && state_d == ST_DONE) alarm_cnt_d = alarm_cnt_q + AW'(1);

    // Blink only runs while staying in EDIT; any other path parks it low.
    if (state_q == ST_EDIT && state_d == ST_EDIT) begin
      if (sel_chg) begin
        blink_d = 1'b1;
      end else if (blink_cnt_q == BLINK_LAST) begin
        blink_d = ~blink_q;
      end else begin
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EDIT;
      tmp1_q      <= PRESET_RST;
      sel_q       <= 3'd0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
      alarm_cnt_q <= '0;
      go_q        <= 1'b0;
      alarm_q     <= 1'b0;
      sync_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      tmp1_q      <= tmp1_d;
      sel_q       <= sel_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      alarm_cnt_q <= alarm_cnt_d;
      go_q        <= go_d;
      alarm_q     <= alarm_d;
      sync_q      <= sync_d;
    end
  end

  assign tmp1      = tmp1_q;
  assign go        = go_q;
  assign sel_digit = sel_q;
  assign blink     = blink_q;
  assign alarm     = alarm_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Randomized + directed bench for countdown_ctrl with a digit-array reference
// model feeding an expected-value queue drained by an independent monitor.
module tb_countdown_ctrl;

  localparam int          AC   = 20;
  localparam int          BD   = 4;
  localparam logic [31:0] PRST = 32'h00F00F10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
  logic        btn_right = 1'b0, btn_center = 1'b0, finish = 1'b0;
  logic [31:0] tmp1;
  logic        go, blink, alarm;
  logic [2:0]  sel_digit;
  logic [1:0]  state_o;

  countdown_ctrl #(.ALARM_CYCLES(AC), .BLINK_DIV(BD), .PRESET_RST(PRST)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right), .btn_center(btn_center),
    .finish(finish), .tmp1(tmp1), .go(go), .sel_digit(sel_digit),
    .blink(blink), .alarm(alarm), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  st;
    logic [31:0] tmp1;
    logic        go;
    logic [2:0]  sel;
    logic        blink;
    logic        alarm;
  } obs_t;

  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  localparam logic [4:0] C = 5'b10000, U = 5'b01000, D = 5'b00100, L = 5'b00010, R = 5'b00001;

  // Reference model: six decimal digits indexed by selection, states 0/1/2.
  int dmax[6] = '{9, 5, 9, 5, 9, 9};
  int npos[6] = '{0, 4, 12, 16, 24, 28};
  int m_dig[6];
  int m_sel, m_state, m_blink, m_bcnt, m_acnt;
  int fin_prev1, fin_prev2;
  int fin_lvl = 0;

  function automatic obs_t model_obs();
    obs_t o;
    o.st    = 2'(m_state);
    o.tmp1  = {4'(m_dig[5]), 4'(m_dig[4]), 4'hF, 4'(m_dig[3]), 4'(m_dig[2]), 4'hF,
               4'(m_dig[1]), 4'(m_dig[0])};
    o.go    = (m_state != 0);
    o.sel   = 3'(m_sel);
    o.blink = (m_blink != 0);
    o.alarm = (m_state == 2);
    return o;
  endfunction

  task automatic model_step(input logic r, input logic [4:0] b, input logic f);
    int ns, edge_seen, sum, k;
    bit selchg;
    if (r) begin
      for (int i = 0; i < 6; i++) m_dig[i] = int'((PRST >> npos[i]) & 32'hF);
      m_sel = 0; m_state = 0; m_blink = 0; m_bcnt = 0; m_acnt = 0;
      fin_prev1 = 0; fin_prev2 = 0;
      return;
    end
    // finish counts only when it was seen high one clock ago and low two ago
    edge_seen = (fin_prev1 == 1 && fin_prev2 == 0);
    ns = m_state;
    selchg = 0;
    k = m_sel;
    case (m_state)
      0: begin
        sum = 0;
        for (int i = 0; i < 6; i++) sum += m_dig[i];
        if (b[4]) begin
          if (sum != 0) ns = 1;
        end else if (b[3]) m_dig[k] = (m_dig[k] + 1) % (dmax[k] + 1);
        else if (b[2]) m_dig[k] = (m_dig[k] + dmax[k]) % (dmax[k] + 1);
        else if (b[1]) begin m_sel = (m_sel + 1) % 6; selchg = 1; end
        else if (b[0]) begin m_sel = (m_sel + 5) % 6; selchg = 1; end
      end
      1: begin
        if (edge_seen) ns = 2;
        else if (b[4]) ns = 0;
      end
      default: begin
        if (b[4] || m_acnt == AC - 1) ns = 0;
      end
    endcase
    m_acnt = (m_state == 2 && ns == 2) ? m_acnt + 1 : 0;
    if (m_state == 0 && ns == 0) begin
      if (selchg) begin m_blink = 1; m_bcnt = 0; end
      else if (m_bcnt == BD - 1) begin m_blink = 1 - m_blink; m_bcnt = 0; end
      else m_bcnt++;
    end else begin
      m_blink = 0; m_bcnt = 0;
    end
    m_state = ns;
    fin_prev2 = fin_prev1;
    fin_prev1 = f;
  endtask

  // Drive one cycle of stimulus and queue the response expected after the edge.
  task automatic step(input logic r, input logic [4:0] b);
    @(negedge clk);
    rst = r;
    btn_center = b[4]; btn_up = b[3]; btn_down = b[2]; btn_left = b[1]; btn_right = b[0];
    finish = fin_lvl[0];
    model_step(r, b, fin_lvl[0]);
    exp_q.push_back(model_obs());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'b0);
  endtask

  // Monitor: every cycle the DUT presents a fresh registered output.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{st: state_o, tmp1: tmp1, go: go, sel: sel_digit, blink: blink, alarm: alarm};
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL outputs t=%0t got st=%0d tmp1=%h go=%b sel=%0d blink=%b alarm=%b want st=%0d tmp1=%h go=%b sel=%0d blink=%b alarm=%b",
                   $time, a.st, a.tmp1, a.go, a.sel, a.blink, a.alarm,
                   e.st, e.tmp1, e.go, e.sel, e.blink, e.alarm);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [4:0] b;
    logic       r;
    // reset
    step(1'b1, 5'b0); step(1'b1, 5'b0);
    idle(6);
    // sec_10 wrap, sec_1 borrow-free wrap, selection wrap
    step(1'b0, L);
    for (int i = 0; i < 7; i++) step(1'b0, U);
    step(1'b0, R); step(1'b0, D); step(1'b0, U);
    for (int i = 0; i < 6; i++) step(1'b0, L);
    // zero guard
    step(1'b0, L); step(1'b0, D); step(1'b0, D); step(1'b0, R);
    step(1'b0, C); idle(2);
    for (int i = 0; i < 3; i++) step(1'b0, U);
    step(1'b0, C); idle(3);
    // abort
    step(1'b0, C); idle(2);
    // stale finish, then a real edge, then alarm timeout
    fin_lvl = 1; idle(4);
    step(1'b0, C); idle(5);
    fin_lvl = 0; idle(3);
    fin_lvl = 1; idle(3);
    idle(25);
    // simultaneous up+left in EDIT
    step(1'b0, U | L); idle(2);
    // finish beats center in RUN, then reset from DONE
    fin_lvl = 0; step(1'b0, C); idle(2);
    fin_lvl = 1; idle(1); step(1'b0, C); idle(3);
    step(1'b1, 5'b0); step(1'b1, 5'b0); idle(3);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      b = '0;
      b[4] = ($urandom_range(0, 15) == 0);
      for (int j = 0; j < 4; j++) b[j] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 14) == 0) fin_lvl = 1 - fin_lvl;
      step(r, b);
    end
    step(1'b0, 5'b0);
    repeat (4) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected vectors left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
Front-panel controller for the BCD countdown datapath. Owns the preset time (edited digit-by-digit from debounced pushbuttons) and sequences the datapath through edit, run and alarm phases. It drives the datapath's preset bus and `go` line, and watches its `finish` flag. It sits between the button debouncers and the countdown datapath, and also feeds digit-select/blink information to the 7-segment display mux.

Parameters:
- ALARM_CYCLES, 500000000, clk cycles the alarm stays asserted in DONE before auto-return to EDIT (10 s at 50 MHz).
- BLINK_DIV, 12500000, clk cycles per half-period of the edit blink signal.
- PRESET_RST, 32'h00F00F10, preset loaded at reset (00:00:10).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- btn_up  in  1  one-cycle pulse; increment the selected digit.
- btn_down  in  1  one-cycle pulse; decrement the selected digit.
- btn_left  in  1  one-cycle pulse; move selection toward hours.
- btn_right  in  1  one-cycle pulse; move selection toward seconds.
- btn_center  in  1  one-cycle pulse; start, abort or acknowledge.
- finish  in  1  datapath zero-reached flag (level, slow-clock domain).
- tmp1  out  32  preset {hr_10,hr_1,4'hF,min_10,min_1,4'hF,sec_10,sec_1}.
- go  out  1  1 = datapath counts; 0 = datapath reloads tmp1.
- sel_digit  out  3  selected digit: 0=sec_1, 1=sec_10, 2=min_1, 3=min_10, 4=hr_1, 5=hr_10.
- blink  out  1  blink phase for the selected digit.
- alarm  out  1  time-up indicator.
- state_o  out  2  current state (for LEDs/debug).

Behaviour:
- Reset values:
  - state=EDIT (2'd0), tmp1=PRESET_RST, go=0, sel_digit=0, blink=0, alarm=0.
  - All internal counters cleared; finish synchronizer cleared.
- Reset mid-RUN or mid-DONE: same values; go drops on the cycle after rst is sampled.
- finish handling:
  - Passed through a 2-flop synchronizer, then a rising-edge detector (sync_q & ~sync_qq).
  - Only a rising edge counts. A finish level already high on RUN entry must NOT cause DONE.
- Digit ranges:
  - sec_1, min_1, hr_1, hr_10: 0-9.
  - sec_10, min_10: 0-5.
  - Filler nibbles are always 4'hF.
- States:
  - EDIT (0), RUN (1), DONE (2). Encoding 3 is illegal and recovers to EDIT on the next cycle.
- EDIT:
  - go=0; blink toggles every BLINK_DIV cycles; alarm=0.
  - btn_up: selected digit +1; wraps from its max to 0.
  - btn_down: selected digit -1; wraps from 0 to its max.
  - No carry or borrow between digits.
  - btn_left: sel_digit +1, 5 wraps to 0. btn_right: sel_digit -1, 0 wraps to 5.
  - Any sel_digit change restarts the blink counter with blink=1.
  - btn_center with a nonzero preset: go to RUN; go=1 from the next cycle.
  - btn_center with preset 00:00:00: ignored, stays in EDIT.
- RUN:
  - go=1, blink=0; tmp1 frozen. btn_up/down/left/right are ignored.
  - btn_center: abort to EDIT; go=0 next cycle, so the datapath reloads the preset.
  - finish rising edge: go to DONE.
- DONE:
  - go stays 1 (datapath holds at zero); alarm=1; alarm counter runs.
  - btn_center, or the counter reaching ALARM_CYCLES-1: return to EDIT; alarm=0 and go=0 next cycle.
  - tmp1 keeps the last preset.
- Simultaneous events:
  - EDIT: several buttons in one cycle resolve by priority center > up > down > left > right; only one action per cycle.
  - RUN: btn_center and a finish edge in the same cycle resolve to DONE (finish wins).
- Latency: every state change and output update is registered, one clk after the causing input.

Test Plan:
1. Reset: rst=1 for 2 cycles -> tmp1=32'h00F00F10, go=0, alarm=0, sel_digit=0, state_o=0.
2. Digit wrap:
   - sel_digit=1, seven btn_up -> sec_10 sequence 2,3,4,5,0,1,2.
   - btn_down at sec_1=0 -> 9.
   - btn_left at sel 5 -> sel 0.
3. Zero guard: edit preset to 32'h00F00F00, press btn_center -> remains EDIT, go=0. Set sec_1=3, press btn_center -> state_o=1, go=1 next cycle.
4. Stale finish:
   - Enter RUN with finish held 1 -> stays RUN.
   - Drop finish to 0 for 3 cycles, then raise -> state_o=2, alarm=1 within 3 cycles (synchronizer + register).
5. Alarm timeout: ALARM_CYCLES=20 in DONE -> alarm=1 for exactly 20 cycles, then state_o=0, go=0, tmp1 unchanged.
6. Abort and priority:
   - btn_center in RUN -> EDIT, go=0.
   - btn_up+btn_left same cycle in EDIT -> only the digit increments.
   - rst asserted in DONE -> all reset values.
